counter_cluster_nch_async_resetp: RTL
=====================================

COUNTER_CLUSTER_NCH_ASYNC_RESETP -- requirements
Module: counter_cluster_nch_async_resetp

Interface
REQ-001 SHALL have parameter NCH, default 3: number of counter channels, minimum 1.
REQ-002 SHALL have parameter WIDTH, default 12: bits per channel, minimum 2.
REQ-003 SHALL have parameter CASCADE, default 0: 0 = independent channels; 1 = channel k steps only on the terminal count of channel k-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, NCH bits: per-channel count enable.
REQ-007 SHALL have port up_dn, input, NCH bits: per-channel direction; 1 = up, 0 = down.
REQ-008 SHALL have port load, input, NCH bits: per-channel synchronous load strobe.
REQ-009 SHALL have port load_val, input, NCH*WIDTH bits: load values; channel k uses bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port count, output, NCH*WIDTH bits: registered channel values, packed like load_val.
REQ-011 SHALL have port tc, output, NCH bits: combinational per-channel terminal-count strobe.
REQ-012 SHALL have port ovf, output, NCH bits: sticky per-channel overflow flags (see REQ-026).

Function
REQ-013 SHALL define step[k] = en[k] when CASCADE=0; when CASCADE=1, step[0] = en[0] and step[k] = en[k] & tc[k-1] for k>=1.
REQ-014 SHALL define terminal[k] as count[k] == all-ones when up_dn[k]=1, and count[k] == 0 when up_dn[k]=0.
REQ-015 SHALL drive tc[k] = step[k] & terminal[k] & ~load[k], with no register stage.
REQ-016 SHALL, per channel per edge, apply priority: load over step over hold.
REQ-017 SHALL set count[k] to load_val[k] on an edge with load[k]=1, regardless of en, up_dn or cascade input.
REQ-018 SHALL, when step[k]=1 and load[k]=0, add 1 (up) or subtract 1 (down) modulo 2^WIDTH; all-ones+1 wraps to 0 and 0-1 wraps to all-ones.
REQ-019 SHALL hold count[k] when load[k]=0 and step[k]=0.
REQ-020 SHALL update count[k] with one-cycle latency from the qualifying edge; the tc of the stepped-from value is visible in the cycle before the wrap edge.
REQ-021 SHALL, with CASCADE=1 and all up_dn=1, behave as a single NCH*WIDTH-bit up counter when all en bits are high.
REQ-022 SHALL sample a direction change only on the edge at which it is present; there is no pipelined direction state.
REQ-023 SHALL block the tc[k-1] ripple into channel k when load[k-1]=1, because REQ-015 suppresses tc[k-1].

Reset
REQ-024 SHALL, while reset=1, asynchronously force every count bit and every ovf bit to 0, independent of clk.
REQ-025 SHALL, after reset deassertion, resume counting on the first rising clk edge; tc reflects inputs immediately because it is combinational.

Configuration
REQ-026 SHALL, with macro COUNTER_CLUSTER_OVF_STICKY_EN defined, set ovf[k] on any edge where tc[k]=1, hold it until load[k]=1 or reset clears it, and give load clear priority over a same-edge set.
REQ-027 SHALL, without COUNTER_CLUSTER_OVF_STICKY_EN, drive ovf to constant 0 and contain no ovf flops; all other behaviour is identical.

Verification (NCH=3, WIDTH=8)
REQ-028 SHALL cover CASCADE=0, en=3'b111, up_dn=3'b111, from reset, 256 edges -> count=0 on every channel; tc=3'b111 during cycle 255 only.
REQ-029 SHALL cover CASCADE=1, en=3'b111, up_dn=3'b111, load count={8'h00,8'hFF,8'hFF}, then 1 edge -> count={8'h01,8'h00,8'h00}, tc was 3'b011 before the edge.
REQ-030 SHALL cover channel 1 loaded with 8'h05 while en[1]=1 and up_dn[1]=0, then 6 edges -> values 04,03,02,01,00,FF; tc[1]=1 only while the value is 00.
REQ-031 SHALL cover load[0]=1 with en[0]=1 at count 8'hFF -> count[0]=load_val[0]; tc[0]=0 and ovf[0] not set on that edge.
REQ-032 SHALL cover, with the macro defined, wrapping channel 2 once -> ovf[2]=1 held for 10 further edges; load[2] pulse -> ovf[2]=0 next edge.
REQ-033 SHALL cover reset asserted mid-count, between clk edges -> count and ovf are 0 immediately; after release, the count resumes from 0 on the next edge.

Source files
------------

// File: rtl/counter_cluster_nch_async_resetp.sv
// rtl/counter_cluster_nch_async_resetp.sv - multi-channel up/down counter cluster with optional cascade
// Optional sticky overflow flags: define COUNTER_CLUSTER_OVF_STICKY_EN.
module counter_cluster_nch_async_resetp #(
    parameter int NCH     = 3,
    parameter int WIDTH   = 12,
    parameter int CASCADE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       up_dn,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       ovf
);

    logic [NCH-1:0][WIDTH-1:0] cnt;
    logic [NCH-1:0]            step_v;
    logic [NCH-1:0]            tc_v;

    assign count = cnt;
    assign tc    = tc_v;

    // Ripple the terminal strobe through a carry variable so each channel sees
    // the already-computed tc of its predecessor.
    always_comb begin
        logic chain;
        logic term;
        step_v = '0;
        tc_v   = '0;
        chain  = 1'b1;
        term   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            term      = up_dn[k] ? (cnt[k] == {WIDTH{1'b1}}) : (cnt[k] == {WIDTH{1'b0}});
            step_v[k] = (CASCADE != 0) ? (en[k] & chain) : en[k];
            tc_v[k]   = step_v[k] & term & ~load[k];
            chain     = tc_v[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    cnt[k] <= load_val[k*WIDTH +: WIDTH];
                end else if (step_v[k]) begin
                    cnt[k] <= up_dn[k] ? cnt[k] + WIDTH'(1) : cnt[k] - WIDTH'(1);
                end
            end
        end
    end

`ifdef COUNTER_CLUSTER_OVF_STICKY_EN
    logic [NCH-1:0] ovf_q;

    // Load clears the flag even if the same edge would have set it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    ovf_q[k] <= 1'b0;
                end else if (tc_v[k]) begin
                    ovf_q[k] <= 1'b1;
                end
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = '0;
`endif

endmodule
